// File: rtl/cic_decimator_pkg.sv
// Shared defaults and width helper for the I/Q CIC decimator.
package cic_decimator_pkg;

   localparam int CIC_N_STAGES = 3;
   localparam int CIC_DECIM    = 64;
   localparam int CIC_IN_W     = 16;
   localparam int CIC_OUT_W    = 16;

   // Register growth of an N-stage, ratio-R, delay-1 CIC is N*log2(R) bits.
   function automatic int cic_acc_w(input int in_w, input int n_stages, input int decim);
      return in_w + n_stages * $clog2(decim);
   endfunction

endpackage

// File: rtl/cic_channel.sv
// Single-rail CIC datapath: pipelined integrators at the input rate, delay-1 combs at the decimated rate.
module cic_channel
   import cic_decimator_pkg::*;
#(
   parameter int N_STAGES = CIC_N_STAGES,
   parameter int IN_W     = CIC_IN_W,
   parameter int OUT_W    = CIC_OUT_W,
   parameter int ACC_W    = cic_acc_w(CIC_IN_W, CIC_N_STAGES, CIC_DECIM)
)
(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    in_valid,
   input  logic signed [IN_W-1:0]  x,
   input  logic                    cap,
   input  logic [N_STAGES:0]       vld_pipe,
   output logic signed [OUT_W-1:0] y
);

   logic [N_STAGES-1:0][ACC_W-1:0] integ;
   logic [N_STAGES-1:0][ACC_W-1:0] int_nxt;
   logic [N_STAGES-1:0][ACC_W-1:0] comb;
   logic [N_STAGES-1:0][ACC_W-1:0] dly;
   logic [N_STAGES-1:0][ACC_W-1:0] comb_src;
   logic [ACC_W-1:0]               x_ext;
   logic [ACC_W-1:0]               cap_q;

   assign x_ext = {{(ACC_W-IN_W){x[IN_W-1]}}, x};

   // Each integrator adds the registered value of the stage before it, so the chain is pipelined.
   always_comb begin
      int_nxt    = '0;
      int_nxt[0] = integ[0] + x_ext;
      for (int k = 1; k < N_STAGES; k++)
         int_nxt[k] = integ[k] + integ[k-1];
   end

   always_comb begin
      comb_src    = '0;
      comb_src[0] = cap_q;
      for (int k = 1; k < N_STAGES; k++)
         comb_src[k] = comb[k-1];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         integ <= '0;
         comb  <= '0;
         dly   <= '0;
         cap_q <= '0;
         y     <= '0;
      end else begin
         if (in_valid)
            integ <= int_nxt;
         if (cap)
            cap_q <= int_nxt[N_STAGES-1];
         // Combs step one stage per clock behind the shared valid token, regardless of in_valid.
         for (int k = 0; k < N_STAGES; k++) begin
            if (vld_pipe[k]) begin
               comb[k] <= comb_src[k] - dly[k];
               dly[k]  <= comb_src[k];
            end
         end
         if (vld_pipe[N_STAGES])
            y <= comb[N_STAGES-1][ACC_W-1 -: OUT_W];
      end
   end

endmodule

// File: rtl/cic_decimator.sv
// I/Q CIC decimator: shared decimation counter and valid pipeline driving two identical channels.
module cic_decimator
   import cic_decimator_pkg::*;
#(
   parameter int N_STAGES = CIC_N_STAGES,
   parameter int DECIM    = CIC_DECIM,
   parameter int IN_W     = CIC_IN_W,
   parameter int OUT_W    = CIC_OUT_W
)
(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    in_valid,
   input  logic signed [IN_W-1:0]  I_in,
   input  logic signed [IN_W-1:0]  Q_in,
   output logic signed [OUT_W-1:0] I_out,
   output logic signed [OUT_W-1:0] Q_out,
   output logic                    out_valid
);

   localparam int ACC_W = cic_acc_w(IN_W, N_STAGES, DECIM);
   localparam int CNT_W = $clog2(DECIM);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM-1);

   logic [CNT_W-1:0]           count;
   logic                       cap;
   // bit 0: capture, bits 1..N_STAGES: comb stages, top bit: output register
   logic [N_STAGES+1:0]        vld_pipe;
   logic [1:0][IN_W-1:0]       x_lane;
   logic [1:0][OUT_W-1:0]      y_lane;

   assign cap = in_valid && (count == CNT_LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         count    <= '0;
         vld_pipe <= '0;
      end else begin
         if (in_valid)
            count <= (count == CNT_LAST) ? '0 : count + 1'b1;
         vld_pipe <= {vld_pipe[N_STAGES:0], cap};
      end
   end

   assign out_valid = vld_pipe[N_STAGES+1];
   assign x_lane[0] = I_in;
   assign x_lane[1] = Q_in;

   for (genvar c = 0; c < 2; c++) begin : g_chan
      cic_channel #(
         .N_STAGES(N_STAGES),
         .IN_W    (IN_W),
         .OUT_W   (OUT_W),
         .ACC_W   (ACC_W)
      ) u_chan (
         .CLK     (CLK),
         .RST     (RST),
         .in_valid(in_valid),
         .x       (x_lane[c]),
         .cap     (cap),
         .vld_pipe(vld_pipe[N_STAGES:0]),
         .y       (y_lane[c])
      );
   end

   assign I_out = y_lane[0];
   assign Q_out = y_lane[1];

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench: CIC output predicted as a boxcar^N FIR over the accepted-sample history.
module tb_cic_decimator;

   localparam int N_STAGES = 3;
   localparam int DECIM    = 64;
   localparam int IN_W     = 16;
   localparam int OUT_W    = 16;
   localparam int ACC_W    = IN_W + N_STAGES * $clog2(DECIM);
   localparam int SHIFT    = ACC_W - OUT_W;
   localparam int HLEN     = N_STAGES * (DECIM - 1) + 1;
   // Pipelined integrators lag the input by one sample per stage after the first.
   localparam int SKEW     = N_STAGES - 1;
   localparam int LAT      = N_STAGES + 2;

   logic                    CLK = 1'b0;
   logic                    RST;
   logic                    in_valid;
   logic signed [IN_W-1:0]  I_in;
   logic signed [IN_W-1:0]  Q_in;
   logic signed [OUT_W-1:0] I_out;
   logic signed [OUT_W-1:0] Q_out;
   logic                    out_valid;

   cic_decimator #(
      .N_STAGES(N_STAGES), .DECIM(DECIM), .IN_W(IN_W), .OUT_W(OUT_W)
   ) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .I_in(I_in), .Q_in(Q_in),
      .I_out(I_out), .Q_out(Q_out), .out_valid(out_valid)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int i;
      int q;
      int due;
   } exp_t;

   exp_t   sb[$];
   int     hist_i[$];
   int     hist_q[$];
   longint h [HLEN];
   int     cyc    = 0;
   int     checks = 0;
   int     errors = 0;
   bit     armed  = 1'b0;
   int     hold_i = 0;
   int     hold_q = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Impulse response of N cascaded length-DECIM moving sums.
   task automatic build_h();
      longint t [HLEN];
      int len;
      foreach (h[m]) h[m] = 0;
      for (int m = 0; m < DECIM; m++) h[m] = 1;
      len = DECIM;
      for (int s = 1; s < N_STAGES; s++) begin
         foreach (t[m]) t[m] = 0;
         for (int a = 0; a < len; a++)
            for (int b = 0; b < DECIM; b++)
               t[a+b] += h[a];
         len += DECIM - 1;
         h = t;
      end
   endtask

   function automatic int ref_out(input bit use_q, input int n);
      longint acc;
      int idx;
      acc = 0;
      for (int m = 0; m < HLEN; m++) begin
         idx = n - SKEW - m;
         if (idx >= 0)
            acc += h[m] * longint'(use_q ? hist_q[idx] : hist_i[idx]);
      end
      return int'(acc >>> SHIFT);
   endfunction

   task automatic step(input bit v, input int i, input int q);
      int n;
      @(posedge CLK); #1;
      in_valid = v;
      I_in     = IN_W'(i);
      Q_in     = IN_W'(q);
      if (v) begin
         hist_i.push_back(i);
         hist_q.push_back(q);
         n = hist_i.size() - 1;
         if (n % DECIM == DECIM - 1)
            sb.push_back('{ref_out(1'b0, n), ref_out(1'b1, n), cyc + LAT});
      end
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      RST      = 1'b1;
      in_valid = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      sb.delete();
      hist_i.delete();
      hist_q.delete();
      hold_i = 0;
      hold_q = 0;
      armed  = 1'b1;
      check("reset_I_out", int'(I_out), 0);
      check("reset_Q_out", int'(Q_out), 0);
      check("reset_out_valid", int'(out_valid), 0);
      @(posedge CLK); #1;
      check("post_reset_out_valid", int'(out_valid), 0);
   endtask

   task automatic drain();
      step(1'b0, 0, 0);
      for (int k = 0; k < 400 && sb.size() != 0; k++) @(posedge CLK);
      #1;
      check("drain_pending", sb.size(), 0);
      sb.delete();
   endtask

   function automatic int rnd_s16();
      return int'($urandom_range(65535)) - 32768;
   endfunction

   // Monitor: every out_valid pops one expectation; between pulses the outputs must hold.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (armed) begin
            if (out_valid === 1'b1) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out_valid: got pulse at cycle %0d, expected none", cyc);
               end else begin
                  e = sb.pop_front();
                  check("I_out", int'(I_out), e.i);
                  check("Q_out", int'(Q_out), e.q);
                  check("out_valid_cycle", cyc, e.due);
               end
               hold_i = int'(I_out);
               hold_q = int'(Q_out);
            end else begin
               check("hold_I_out", int'(I_out), hold_i);
               check("hold_Q_out", int'(Q_out), hold_q);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      RST      = 1'b1;
      in_valid = 1'b0;
      I_in     = '0;
      Q_in     = '0;
      build_h();
      repeat (3) @(posedge CLK);

      // DC, continuous input
      do_reset();
      for (int n = 0; n < 8 * DECIM; n++) step(1'b1, 1000, -1000);
      drain();
      check("dc_settled_I", int'(I_out), 1000);
      check("dc_settled_Q", int'(Q_out), -1000);

      // full scale
      do_reset();
      for (int n = 0; n < 6 * DECIM; n++) step(1'b1, -32768, 32767);
      drain();
      check("fs_settled_I", int'(I_out), -32768);
      check("fs_settled_Q", int'(Q_out), 32767);

      // in_valid toggling, junk on idle cycles
      do_reset();
      for (int n = 0; n < 6 * DECIM; n++) begin
         step(1'b1, 1000, -1000);
         step(1'b0, rnd_s16(), rnd_s16());
      end
      drain();
      check("stall_settled_I", int'(I_out), 1000);
      check("stall_settled_Q", int'(Q_out), -1000);

      // reset at sample 30 of the third block, then restart
      do_reset();
      for (int n = 0; n < 2 * DECIM + 30; n++) step(1'b1, 1000, -1000);
      do_reset();
      for (int n = 0; n < 5 * DECIM; n++) step(1'b1, 1000, -1000);
      drain();
      check("restart_settled_I", int'(I_out), 1000);

      // Nyquist tone on I only
      do_reset();
      for (int n = 0; n < 6 * DECIM; n++) step(1'b1, (n % 2 == 0) ? 16384 : -16384, 0);
      drain();
      check("nyq_settled_I", int'(I_out), 0);
      check("nyq_Q", int'(Q_out), 0);

      // reset right after a capture must kill the in-flight result
      do_reset();
      for (int n = 0; n < DECIM; n++) step(1'b1, 500, -700);
      do_reset();
      for (int n = 0; n < 8; n++) step(1'b0, 0, 0);
      check("inflight_discarded", sb.size(), 0);

      // random data with random gaps
      do_reset();
      while (hist_i.size() < 10 * DECIM)
         step(($urandom % 10) < 7, rnd_s16(), rnd_s16());
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
